// File: rtl/frame_buffer_arbiter.sv
// Frame buffer port arbiter: scan-out reads win every cycle; the clear sweep and a
// one-entry writer hold register share whatever cycles the display leaves idle.
module frame_buffer_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 307200
) (
  input  logic              video_clk,
  input  logic              rst_n,
  input  logic              disp_rd_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic                r_clear_busy;
  logic [ADDR_W-1:0]   r_clr_addr;

  logic                r_hold_full;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic [DATA_W-1:0]   r_hold_data;

  logic                r_rd_d1;
  logic                r_disp_valid;
  logic [DATA_W-1:0]   r_disp_data;

  logic                w_idle;
  logic                w_drain_now;
  logic                w_wr_ready;
  logic                w_wr_xfer;
  logic                w_wr_keep;
  logic                w_clr_write;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_drain_now = r_hold_full & ~disp_rd_en & w_idle;
  // Gated by rst_n so the writer sees no ready while the block is held in reset.
  assign w_wr_ready  = rst_n & w_idle & (~r_hold_full | w_drain_now);
  assign w_wr_xfer   = wr_valid & w_wr_ready;
  assign w_wr_keep   = w_wr_xfer & (wr_addr < DEPTH_A);
  assign w_clr_write = (r_state == ST_CLEAR) & ~disp_rd_en;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the if/else chain leaves a signal unassigned and infers a latch.
  always_comb begin
    bram_addr = disp_addr;
    bram_we   = 1'b0;
    bram_din  = '0;
    if (disp_rd_en) begin
      bram_addr = disp_addr;
    end else if (r_state == ST_CLEAR) begin
      bram_addr = r_clr_addr;
      bram_we   = 1'b1;
    end else if (w_drain_now) begin
      bram_addr = r_hold_addr;
      bram_we   = 1'b1;
      bram_din  = r_hold_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_clear_busy <= 1'b0;
      r_clr_addr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state      <= ST_CLEAR;
            r_clear_busy <= 1'b1;
            r_clr_addr   <= '0;
          end
        end
        ST_CLEAR: begin
          // A display read steals the cycle; the sweep address simply waits.
          if (w_clr_write) begin
            if (r_clr_addr == LAST_ADDR) begin
              r_state      <= ST_IDLE;
              r_clear_busy <= 1'b0;
            end else begin
              r_clr_addr <= r_clr_addr + 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range transfers complete the handshake but never load the hold register.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else if (w_wr_keep) begin
      r_hold_full <= 1'b1;
      r_hold_addr <= wr_addr;
      r_hold_data <= wr_data;
    end else if (w_drain_now) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d1      <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_rd_d1      <= disp_rd_en;
      r_disp_valid <= r_rd_d1;
      r_disp_data  <= r_rd_d1 ? bram_dout : '0;
    end
  end

  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
  assign wr_ready   = w_wr_ready;
  assign clear_busy = r_clear_busy;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter with a behavioural BRAM, a write-order
// scoreboard and a reduced frame depth so a full clear sweep stays short.
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 4096;
  localparam int MEM_AW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              video_clk = 1'b0;
  logic              rst_n;
  logic              disp_rd_en;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              clear_req;
  logic              clear_busy;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  always #5 video_clk = ~video_clk;

  frame_buffer_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .disp_rd_en(disp_rd_en),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .bram_addr (bram_addr),
    .bram_we   (bram_we),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  // Single-port BRAM, read-first, one cycle read latency.
  always @(posedge video_clk) begin
    if (bram_addr < ADDR_W'(DEPTH)) begin
      if (bram_we) mem[bram_addr[MEM_AW-1:0]] <= bram_din;
      bram_dout <= mem[bram_addr[MEM_AW-1:0]];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    disp_rd_en = 1'b0;
    disp_addr  = '0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    clear_req  = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] mem_at(input int a);
    logic [MEM_AW-1:0] idx;
    idx = MEM_AW'(a);
    return mem[idx];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    disp_rd_en = 1'b1;
    disp_addr  = ADDR_W'(7);
    wr_valid   = 1'b1;
    wr_addr    = ADDR_W'(20);
    wr_data    = 3'd2;
    clear_req  = 1'b1;
    tick();
    clear_req = 1'b0;
    wr_valid  = 1'b0;
    repeat (4) tick();
    checks++;
    if (disp_valid !== 1'b1 || clear_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_precondition: disp_valid=%0b clear_busy=%0b expected 1 1", disp_valid, clear_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({disp_valid, disp_data, clear_busy, bram_we, wr_ready} !== '0) begin
      errors++;
      $display("FAIL reset_async_outputs: valid=%0b data=%0d busy=%0b we=%0b ready=%0b expected all 0",
               disp_valid, disp_data, clear_busy, bram_we, wr_ready);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    checks++;
    if (wr_ready !== 1'b1 || disp_valid !== 1'b0 || clear_busy !== 1'b0 || bram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b valid=%0b busy=%0b we=%0b expected 1 0 0 0",
               wr_ready, disp_valid, clear_busy, bram_we);
    end
  endtask

  task automatic test_read_latency();
    mem[5] = 3'd3;
    disp_rd_en = 1'b1;
    disp_addr  = ADDR_W'(5);
    settle();
    checks++;
    if (bram_we !== 1'b0 || bram_addr !== ADDR_W'(5)) begin
      errors++;
      $display("FAIL latency_issue: we=%0b addr=%0d expected 0 5", bram_we, bram_addr);
    end
    tick();
    disp_rd_en = 1'b0;
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: disp_valid=%0b expected 0", disp_valid);
    end
    tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== 3'd3) begin
      errors++;
      $display("FAIL latency_data: valid=%0b data=%0d expected 1 3", disp_valid, disp_data);
    end
    tick();
    checks++;
    if (disp_valid !== 1'b0 || disp_data !== 3'd0) begin
      errors++;
      $display("FAIL latency_after: valid=%0b data=%0d expected 0 0", disp_valid, disp_data);
    end
  endtask

  task automatic test_random_reads();
    localparam int N = 200;
    logic              exp_en [N];
    logic [DATA_W-1:0] exp_d  [N];
    int a;
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        a          = int'($urandom_range(0, DEPTH - 1));
        exp_en[i]  = ($urandom_range(0, 2) != 0);
        exp_d[i]   = exp_en[i] ? mem_at(a) : '0;
        disp_rd_en = exp_en[i];
        disp_addr  = ADDR_W'(a);
      end else begin
        disp_rd_en = 1'b0;
      end
      tick();
      if (i >= 1) begin
        checks++;
        if (disp_valid !== exp_en[i-1] || disp_data !== exp_d[i-1]) begin
          errors++;
          $display("FAIL random_read[%0d]: valid=%0b data=%0d expected %0b %0d",
                   i - 1, disp_valid, disp_data, exp_en[i-1], exp_d[i-1]);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    disp_rd_en = 1'b1;
    disp_addr  = '0;
    wr_valid   = 1'b1;
    wr_addr    = ADDR_W'(300);
    wr_data    = 3'd1;
    settle();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_first_ready: wr_ready=%0b expected 1", wr_ready);
    end
    tick();
    wr_addr = ADDR_W'(301);
    wr_data = 3'd4;
    settle();
    checks++;
    if (wr_ready !== 1'b0 || bram_we !== 1'b0) begin
      errors++;
      $display("FAIL contention_stall: ready=%0b we=%0b expected 0 0", wr_ready, bram_we);
    end
    tick();
    settle();
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL contention_stall2: wr_ready=%0b expected 0", wr_ready);
    end
    disp_rd_en = 1'b0;
    settle();
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== ADDR_W'(300) || bram_din !== 3'd1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_drain: we=%0b addr=%0d din=%0d ready=%0b expected 1 300 1 1",
               bram_we, bram_addr, bram_din, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    settle();
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== ADDR_W'(301) || bram_din !== 3'd4 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_second: we=%0b addr=%0d din=%0d ready=%0b expected 1 301 4 1",
               bram_we, bram_addr, bram_din, wr_ready);
    end
    tick();
    settle();
    checks++;
    if (bram_we !== 1'b0 || mem_at(300) !== 3'd1 || mem_at(301) !== 3'd4) begin
      errors++;
      $display("FAIL contention_result: we=%0b mem300=%0d mem301=%0d expected 0 1 4",
               bram_we, mem_at(300), mem_at(301));
    end
  endtask

  task automatic test_random_writes();
    wr_t q[$];
    wr_t e;
    logic exp_ready;
    logic exp_we;
    for (int i = 0; i < 401; i++) begin
      if (i < 400) begin
        disp_rd_en = ($urandom_range(0, 2) == 0);
        disp_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
        wr_valid   = ($urandom_range(0, 3) != 0);
        wr_addr    = ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH + int'($urandom_range(0, 10)))
                                                 : ADDR_W'($urandom_range(0, DEPTH - 1));
        wr_data    = DATA_W'($urandom_range(0, 7));
      end else begin
        idle_inputs();
      end
      settle();
      exp_we    = (q.size() != 0) && !disp_rd_en;
      exp_ready = (q.size() == 0) || !disp_rd_en;
      checks++;
      if (wr_ready !== exp_ready || bram_we !== exp_we) begin
        errors++;
        $display("FAIL random_write_hs[%0d]: ready=%0b we=%0b expected %0b %0b",
                 i, wr_ready, bram_we, exp_ready, exp_we);
      end
      if (exp_we && bram_we === 1'b1) begin
        e = q.pop_front();
        checks++;
        if (bram_addr !== e.a || bram_din !== e.d) begin
          errors++;
          $display("FAIL random_write_data[%0d]: addr=%0d din=%0d expected %0d %0d",
                   i, bram_addr, bram_din, e.a, e.d);
        end
      end else if (exp_we) begin
        void'(q.pop_front());
      end
      if (wr_valid && wr_ready && wr_addr < ADDR_W'(DEPTH)) q.push_back('{a: wr_addr, d: wr_data});
      tick();
    end
  endtask

  task automatic test_out_of_range();
    logic seen_we;
    idle_inputs();
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(DEPTH);
    wr_data  = 3'd5;
    settle();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_accept: wr_ready=%0b expected 1", wr_ready);
    end
    seen_we = bram_we;
    tick();
    wr_valid = 1'b0;
    repeat (4) begin
      settle();
      seen_we |= bram_we;
      tick();
    end
    checks++;
    if (seen_we !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_write: bram_we seen=%0b expected 0", seen_we);
    end
  endtask

  task automatic test_clear_with_display();
    int wcount [DEPTH];
    int cyc = 0;
    int bad_din = 0, bad_ready = 0, early_fall = 0, bad_count = 0, bad_mem = 0;
    logic last_now, last_seen = 1'b0, held_ok = 1'b0, held_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wcount[i] = 0;
      mem[i]    = DATA_W'($urandom_range(1, 7));
    end
    idle_inputs();
    disp_rd_en = 1'b1;
    disp_addr  = ADDR_W'(0);
    clear_req  = 1'b1;
    wr_valid   = 1'b1;
    wr_addr    = ADDR_W'(100);
    wr_data    = 3'd6;
    settle();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_same_cycle_write: wr_ready=%0b expected 1", wr_ready);
    end
    tick();
    cyc++;
    clear_req = 1'b0;
    wr_valid  = 1'b0;
    for (int k = 0; k < 40000 && !held_seen; k++) begin
      disp_rd_en = ((cyc % 800) < 640);
      disp_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      settle();
      last_now = 1'b0;
      if (clear_busy && wr_ready) bad_ready++;
      if (!last_seen && !clear_busy) early_fall++;
      if (bram_we) begin
        if (clear_busy) begin
          if (bram_din !== '0) bad_din++;
          if (bram_addr < ADDR_W'(DEPTH)) wcount[bram_addr[MEM_AW-1:0]]++;
          if (bram_addr == ADDR_W'(DEPTH - 1)) last_now = 1'b1;
        end else begin
          held_seen = 1'b1;
          held_ok   = (bram_addr == ADDR_W'(100)) && (bram_din == 3'd6);
        end
      end
      tick();
      cyc++;
      if (last_now) begin
        last_seen = 1'b1;
        checks++;
        if (clear_busy !== 1'b0) begin
          errors++;
          $display("FAIL clear_busy_fall: clear_busy=%0b expected 0", clear_busy);
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (wcount[i] != 1) bad_count++;
      if (i == 100 ? (mem[i] !== 3'd6) : (mem[i] !== 3'd0)) bad_mem++;
    end
    checks++;
    if (!last_seen || !held_seen || !held_ok) begin
      errors++;
      $display("FAIL clear_completion: last=%0b held_seen=%0b held_ok=%0b expected 1 1 1",
               last_seen, held_seen, held_ok);
    end
    checks++;
    if (bad_count != 0 || bad_din != 0) begin
      errors++;
      $display("FAIL clear_coverage: addrs_not_once=%0d nonzero_din=%0d expected 0 0", bad_count, bad_din);
    end
    checks++;
    if (bad_ready != 0 || early_fall != 0) begin
      errors++;
      $display("FAIL clear_flags: ready_during_clear=%0d early_busy_fall=%0d expected 0 0", bad_ready, early_fall);
    end
    checks++;
    if (bad_mem != 0) begin
      errors++;
      $display("FAIL clear_contents: wrong_words=%0d expected 0", bad_mem);
    end
    idle_inputs();
    disp_rd_en = 1'b1;
    disp_addr  = ADDR_W'(100);
    tick();
    disp_rd_en = 1'b0;
    tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== 3'd6) begin
      errors++;
      $display("FAIL clear_readback_100: valid=%0b data=%0d expected 1 6", disp_valid, disp_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic found = 1'b0, seen_we = 1'b0, seen_busy = 1'b0;
    idle_inputs();
    mem[999]  = 3'd7;
    mem[1000] = 3'd5;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < DEPTH + 10 && !found; k++) begin
      settle();
      if (bram_we && bram_addr == ADDR_W'(1000)) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midsweep_reach: reached clr_addr 1000=%0b expected 1", found);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (clear_busy !== 1'b0 || bram_we !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_abort: busy=%0b we=%0b expected 0 0", clear_busy, bram_we);
    end
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      settle();
      seen_we   |= bram_we;
      seen_busy |= clear_busy;
    end
    checks++;
    if (seen_we !== 1'b0 || seen_busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_no_resume: we=%0b busy=%0b ready=%0b expected 0 0 1", seen_we, seen_busy, wr_ready);
    end
    checks++;
    if (mem_at(999) !== 3'd0 || mem_at(1000) !== 3'd5) begin
      errors++;
      $display("FAIL midsweep_memory: mem999=%0d mem1000=%0d expected 0 5", mem_at(999), mem_at(1000));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 7));
    test_reset();
    test_read_latency();
    test_random_reads();
    test_contention();
    test_random_writes();
    test_out_of_range();
    test_clear_with_display();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
